// File: rtl/mem_access_scheduler_if.sv
// Bus bundle between the memory access scheduler and its neighbours: load RS,
// store-commit path, memory unit, writeback, plus the store-buffer occupancy.
interface mem_access_scheduler_if #(
  parameter int SB_DEPTH = 4,
  parameter int ROB_IX_W = 3
);
  logic                          ld_valid_in;
  logic                          ld_ready_out;
  logic [31:0]                   ld_addr_in;
  logic [ROB_IX_W-1:0]           ld_rob_ix_in;
  logic                          st_valid_in;
  logic                          st_ready_out;
  logic [31:0]                   st_addr_in;
  logic [31:0]                   st_data_in;
  logic                          mu_valid_out;
  logic                          mu_load_or_store_out;
  logic [31:0]                   mu_load_addr_out;
  logic [ROB_IX_W-1:0]           mu_load_rob_ix_out;
  logic [31:0]                   mu_store_addr_out;
  logic [31:0]                   mu_store_data_out;
  logic                          mu_ready_in;
  logic                          mu_valid_in;
  logic [ROB_IX_W-1:0]           mu_rob_ix_in;
  logic [31:0]                   mu_data_in;
  logic                          mu_read_out;
  logic                          res_valid_out;
  logic                          res_ready_in;
  logic [ROB_IX_W-1:0]           res_rob_ix_out;
  logic [31:0]                   res_data_out;
  logic [$clog2(SB_DEPTH):0]     sb_count_out;

  modport slave (
    input  ld_valid_in, ld_addr_in, ld_rob_ix_in,
    input  st_valid_in, st_addr_in, st_data_in,
    input  mu_ready_in, mu_valid_in, mu_rob_ix_in, mu_data_in,
    input  res_ready_in,
    output ld_ready_out, st_ready_out,
    output mu_valid_out, mu_load_or_store_out, mu_load_addr_out, mu_load_rob_ix_out,
    output mu_store_addr_out, mu_store_data_out, mu_read_out,
    output res_valid_out, res_rob_ix_out, res_data_out, sb_count_out
  );

  modport master (
    output ld_valid_in, ld_addr_in, ld_rob_ix_in,
    output st_valid_in, st_addr_in, st_data_in,
    output mu_ready_in, mu_valid_in, mu_rob_ix_in, mu_data_in,
    output res_ready_in,
    input  ld_ready_out, st_ready_out,
    input  mu_valid_out, mu_load_or_store_out, mu_load_addr_out, mu_load_rob_ix_out,
    input  mu_store_addr_out, mu_store_data_out, mu_read_out,
    input  res_valid_out, res_rob_ix_out, res_data_out, sb_count_out
  );
endinterface

// File: rtl/mem_access_scheduler.sv
// Arbitrates a single-ported memory unit between an in-order committed-store
// FIFO and one outstanding load, returning load results to writeback.
//
// state     | meaning
// IDLE      | may issue a store or the held load
// LOAD_WAIT | load issued, waiting for memory data; nothing issues
// RESULT    | result presented to writeback; stores may still issue
module mem_access_scheduler #(
  parameter int SB_DEPTH = 4,
  parameter int ROB_IX_W = 3
) (
  input logic                     clk_in,
  input logic                     rst_in,
  mem_access_scheduler_if.slave   bus
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESULT} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         sb_addr_q [SB_DEPTH];
  logic [31:0]         sb_addr_d [SB_DEPTH];
  logic [31:0]         sb_data_q [SB_DEPTH];
  logic [31:0]         sb_data_d [SB_DEPTH];
  logic                ld_held_q, ld_held_d;
  logic [31:0]         ld_addr_q, ld_addr_d;
  logic [ROB_IX_W-1:0] ld_rob_ix_q, ld_rob_ix_d;
  logic [31:0]         res_data_q, res_data_d;
  logic [ROB_IX_W-1:0] res_rob_ix_q, res_rob_ix_d;

  logic sb_full, sb_nonempty, conflict, st_push, st_issue, ld_issue, res_hs;

  assign sb_full     = (count_q == CNT_W'(SB_DEPTH));
  assign sb_nonempty = (count_q != '0);

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q) &&
          (sb_addr_q[i][31:2] == ld_addr_q[31:2]))
        conflict = 1'b1;
    end
  end

  assign ld_issue = bus.mu_ready_in && (state_q == IDLE) && ld_held_q &&
                    !conflict && !sb_full;
  assign st_issue = bus.mu_ready_in && (state_q != LOAD_WAIT) && sb_nonempty &&
                    !ld_issue;
  assign st_push  = bus.st_valid_in && bus.st_ready_out;
  assign res_hs   = (state_q == RESULT) && bus.res_ready_in;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CNT_W'(st_push) - CNT_W'(st_issue);
    sb_addr_d    = sb_addr_q;
    sb_data_d    = sb_data_q;
    ld_held_d    = ld_held_q;
    ld_addr_d    = ld_addr_q;
    ld_rob_ix_d  = ld_rob_ix_q;
    res_data_d   = res_data_q;
    res_rob_ix_d = res_rob_ix_q;
    if (st_push) begin
      sb_addr_d[wr_ptr_q] = bus.st_addr_in;
      sb_data_d[wr_ptr_q] = bus.st_data_in;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (st_issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (bus.ld_valid_in && !ld_held_q) begin
      ld_held_d   = 1'b1;
      ld_addr_d   = bus.ld_addr_in;
      ld_rob_ix_d = bus.ld_rob_ix_in;
    end
    case (state_q)
      IDLE:      if (ld_issue) state_d = LOAD_WAIT;
      LOAD_WAIT: if (bus.mu_valid_in) begin
                   res_data_d   = bus.mu_data_in;
                   res_rob_ix_d = bus.mu_rob_ix_in;
                   state_d      = RESULT;
                 end
      RESULT:    if (res_hs) begin
                   ld_held_d = 1'b0;
                   state_d   = IDLE;
                 end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ld_held_q    <= 1'b0;
      ld_addr_q    <= '0;
      ld_rob_ix_q  <= '0;
      res_data_q   <= '0;
      res_rob_ix_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ld_held_q    <= ld_held_d;
      ld_addr_q    <= ld_addr_d;
      ld_rob_ix_q  <= ld_rob_ix_d;
      res_data_q   <= res_data_d;
      res_rob_ix_q <= res_rob_ix_d;
      sb_addr_q    <= sb_addr_d;
      sb_data_q    <= sb_data_d;
    end
  end

  // The load register stays occupied through RESULT, so a new load can only
  // be taken the cycle after the writeback handshake.
  assign bus.ld_ready_out         = !ld_held_q;
  assign bus.st_ready_out         = (count_q < CNT_W'(SB_DEPTH));
  assign bus.mu_valid_out         = st_issue || ld_issue;
  assign bus.mu_load_or_store_out = !(ld_issue || (state_q == LOAD_WAIT));
  assign bus.mu_load_addr_out     = ld_addr_q;
  assign bus.mu_load_rob_ix_out   = ld_rob_ix_q;
  assign bus.mu_store_addr_out    = sb_addr_q[rd_ptr_q];
  assign bus.mu_store_data_out    = sb_data_q[rd_ptr_q];
  assign bus.mu_read_out          = (state_q == LOAD_WAIT) && bus.mu_valid_in;
  assign bus.res_valid_out        = (state_q == RESULT);
  assign bus.res_rob_ix_out       = res_rob_ix_q;
  assign bus.res_data_out         = res_data_q;
  assign bus.sb_count_out         = count_q;
endmodule
